uart_cmd_rx: RTL

Receive side of the telemetry UART link: accepts command packets from the host PC over a single serial line and converts them into a demanded shaft angle and an operating mode for the control path. It deserialises 8N1 frames with mid-bit sampling, validates a 5-byte packet with an XOR checksum, and reports errors through a pulse, a code and a saturating counter. It sits between the board `uart_Rx` pin and the angle/mode selection logic beside `DriveControl`, with the same speed and fixed-point format as the telemetry transmitter.

---
 rtl/uart_cmd_rx_if.sv | 23 ++
 rtl/uart_cmd_rx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_rx_if.sv
// Command-receiver signal bundle: serial line and enable in, accepted command and error status out.
interface uart_cmd_rx_if #(
  parameter int unsigned ANGLE_FIXED_LEN = 16
);
  logic                       enable_i;
  logic                       rx_i;
  logic [ANGLE_FIXED_LEN-1:0] angle_demanded_o;
  logic [1:0]                 mode_o;
  logic                       cmd_valid_o;
  logic                       err_o;
  logic [1:0]                 err_code_o;
  logic [7:0]                 err_cnt_o;

  modport master (
    output enable_i, rx_i,
    input  angle_demanded_o, mode_o, cmd_valid_o, err_o, err_code_o, err_cnt_o
  );

  modport slave (
    input  enable_i, rx_i,
    output angle_demanded_o, mode_o, cmd_valid_o, err_o, err_code_o, err_cnt_o
  );
endinterface

// File: rtl/uart_cmd_rx.sv
// 8N1 UART command receiver: deserialises bytes and validates 5-byte A5/CMD/DHI/DLO/CHK
// packets into a demanded angle and mode, reporting framing, checksum, command and timeout errors.
module uart_cmd_rx #(
  parameter int unsigned CLK_FREQ_HZ     = 50_000_000,
  parameter int unsigned SPEED           = 230_400,
  parameter int unsigned ANGLE_FIXED_LEN = 16,
  parameter int unsigned TIMEOUT_BITS    = 20
) (
  input  logic        clk_i,
  input  logic        reset_i,
  uart_cmd_rx_if.slave bus
);

  localparam int unsigned DIV  = CLK_FREQ_HZ / SPEED;
  localparam int unsigned HALF = DIV / 2;
  localparam int unsigned TMO  = TIMEOUT_BITS * DIV;
  localparam int unsigned BW   = $clog2(DIV + 1);
  localparam int unsigned TW   = $clog2(TMO + 1);

  localparam logic [7:0] HDR_BYTE  = 8'hA5;
  localparam logic [7:0] CMD_ANGLE = 8'h01;
  localparam logic [7:0] CMD_MODE  = 8'h02;

  typedef enum logic [2:0] {B_IDLE, B_START, B_DATA, B_STOP, B_BRK} byte_state_t;
  typedef enum logic [2:0] {P_HDR, P_CMD, P_DHI, P_DLO, P_CHK} pkt_state_t;

  logic rx_meta, rxs;

  byte_state_t byte_state, byte_nxt;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          byte_valid, frame_err;
  logic          baud_clr_c, shift_en_c, stop_ok_c, stop_bad_c;

  pkt_state_t  pkt_state, pkt_nxt;
  logic [7:0]  cmd_q, dhi_q, dlo_q;
  logic [TW-1:0] tmo_cnt;
  logic        tmo_hit_c;
  logic        st_cmd_c, st_dhi_c, st_dlo_c, ang_ld_c, mode_ld_c, err_c;
  logic [1:0]  code_c;

  logic [ANGLE_FIXED_LEN-1:0] angle_q;
  logic [1:0]  mode_q, err_code_q;
  logic        cmd_valid_q, err_q;
  logic [7:0]  err_cnt_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= bus.rx_i;
      rxs     <= rx_meta;
    end
  end

  // Byte deserialiser: mid-bit sampling timed from the synchronised start edge
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) byte_state <= B_IDLE;
    else         byte_state <= byte_nxt;
  end

  always_comb begin
    byte_nxt   = byte_state;
    baud_clr_c = 1'b0;
    shift_en_c = 1'b0;
    stop_ok_c  = 1'b0;
    stop_bad_c = 1'b0;
    unique case (byte_state)
      B_IDLE: if (!rxs) begin
        baud_clr_c = 1'b1;
        byte_nxt   = B_START;
      end
      B_START: if (baud_cnt == BW'(HALF - 1)) begin
        baud_clr_c = 1'b1;
        byte_nxt   = rxs ? B_IDLE : B_DATA;
      end
      B_DATA: if (baud_cnt == BW'(DIV - 1)) begin
        baud_clr_c = 1'b1;
        shift_en_c = 1'b1;
        if (bit_cnt == 3'd7) byte_nxt = B_STOP;
      end
      B_STOP: if (baud_cnt == BW'(DIV - 1)) begin
        baud_clr_c = 1'b1;
        if (rxs) begin
          stop_ok_c = 1'b1;
          byte_nxt  = B_IDLE;
        end else begin
          stop_bad_c = 1'b1;
          byte_nxt   = B_BRK;
        end
      end
      B_BRK: if (rxs) byte_nxt = B_IDLE;
      default: byte_nxt = B_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      baud_cnt   <= baud_clr_c ? '0 : baud_cnt + BW'(1);
      if (byte_state == B_IDLE) bit_cnt <= '0;
      else if (shift_en_c)      bit_cnt <= bit_cnt + 3'd1;
      if (shift_en_c) shift <= {rxs, shift[7:1]};
      byte_valid <= stop_ok_c;
      frame_err  <= stop_bad_c;
    end
  end

  // Packet parser; framing beats byte arrival beats timeout
  assign tmo_hit_c = (pkt_state != P_HDR) && (tmo_cnt == TW'(TMO - 1));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) pkt_state <= P_HDR;
    else         pkt_state <= pkt_nxt;
  end

  always_comb begin
    pkt_nxt   = pkt_state;
    st_cmd_c  = 1'b0;
    st_dhi_c  = 1'b0;
    st_dlo_c  = 1'b0;
    ang_ld_c  = 1'b0;
    mode_ld_c = 1'b0;
    err_c     = 1'b0;
    code_c    = 2'd0;
    if (frame_err) begin
      err_c   = 1'b1;
      code_c  = 2'd1;
      pkt_nxt = P_HDR;
    end else if (byte_valid) begin
      if (!bus.enable_i) begin
        pkt_nxt = P_HDR;
      end else begin
        unique case (pkt_state)
          P_HDR: if (shift == HDR_BYTE) pkt_nxt = P_CMD;
          P_CMD: begin st_cmd_c = 1'b1; pkt_nxt = P_DHI; end
          P_DHI: begin st_dhi_c = 1'b1; pkt_nxt = P_DLO; end
          P_DLO: begin st_dlo_c = 1'b1; pkt_nxt = P_CHK; end
          P_CHK: begin
            pkt_nxt = P_HDR;
            if (shift != (cmd_q ^ dhi_q ^ dlo_q)) begin
              err_c  = 1'b1;
              code_c = 2'd2;
            end else if (cmd_q == CMD_ANGLE) begin
              ang_ld_c = 1'b1;
            end else if (cmd_q == CMD_MODE) begin
              mode_ld_c = 1'b1;
            end else begin
              err_c  = 1'b1;
              code_c = 2'd0;
            end
          end
          default: pkt_nxt = P_HDR;
        endcase
      end
    end else if (tmo_hit_c) begin
      err_c   = 1'b1;
      code_c  = 2'd3;
      pkt_nxt = P_HDR;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cmd_q       <= '0;
      dhi_q       <= '0;
      dlo_q       <= '0;
      tmo_cnt     <= '0;
      angle_q     <= '0;
      mode_q      <= '0;
      cmd_valid_q <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (st_cmd_c) cmd_q <= shift;
      if (st_dhi_c) dhi_q <= shift;
      if (st_dlo_c) dlo_q <= shift;
      if (pkt_state == P_HDR || byte_valid) tmo_cnt <= '0;
      else                                  tmo_cnt <= tmo_cnt + TW'(1);
      if (ang_ld_c)  angle_q <= ANGLE_FIXED_LEN'({dhi_q, dlo_q});
      if (mode_ld_c) mode_q  <= dlo_q[1:0];
      cmd_valid_q <= ang_ld_c | mode_ld_c;
      err_q       <= err_c;
      err_code_q  <= code_c;
      if (err_c && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.angle_demanded_o = angle_q;
  assign bus.mode_o           = mode_q;
  assign bus.cmd_valid_o      = cmd_valid_q;
  assign bus.err_o            = err_q;
  assign bus.err_code_o       = err_code_q;
  assign bus.err_cnt_o        = err_cnt_q;

endmodule
